// File: rtl/poly_arith_pkg.sv
// Shared definitions for the polynomial-arithmetic blocks (ML-KEM, Q = 3329).
//   COEF_W      : coefficient width in bits
//   coeff_t     : one coefficient, canonical range [0, Q-1]
//   Q           : ML-KEM modulus
//   N_COEFFS    : coefficients per polynomial
//   pas_state_t : sequencer states of poly_add_sub_ctrl
package poly_arith_pkg;

  localparam int COEF_W   = 12;
  localparam int Q        = 3329;
  localparam int N_COEFFS = 256;

  typedef logic [COEF_W-1:0] coeff_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } pas_state_t;

endpackage

// File: rtl/poly_add_sub_ctrl_if.sv
// Command and coefficient-memory bus of poly_add_sub_ctrl.
//   start_i, is_sub_i          : command from the poly-arith decoder
//   busy_o, done_o             : status back to the decoder
//   rd_en_o, rd_addr_o         : shared read port of source memories A and B
//   rd_a_data_i, rd_b_data_i   : read data, one cycle after rd_en_o
//   wr_en_o, wr_addr_o, wr_data_o : destination memory write port
// Modport master is the sequencer, slave is its environment.
interface poly_add_sub_ctrl_if #(
  parameter int N_COEFFS = poly_arith_pkg::N_COEFFS
);
  import poly_arith_pkg::*;

  localparam int ADDR_W = $clog2(N_COEFFS);

  logic              start_i;
  logic              is_sub_i;
  logic              busy_o;
  logic              done_o;
  logic              rd_en_o;
  logic [ADDR_W-1:0] rd_addr_o;
  coeff_t            rd_a_data_i;
  coeff_t            rd_b_data_i;
  logic              wr_en_o;
  logic [ADDR_W-1:0] wr_addr_o;
  coeff_t            wr_data_o;

  modport master (
    input  start_i, is_sub_i, rd_a_data_i, rd_b_data_i,
    output busy_o, done_o, rd_en_o, rd_addr_o, wr_en_o, wr_addr_o, wr_data_o
  );

  modport slave (
    output start_i, is_sub_i, rd_a_data_i, rd_b_data_i,
    input  busy_o, done_o, rd_en_o, rd_addr_o, wr_en_o, wr_addr_o, wr_data_o
  );

endinterface

// File: rtl/mod_uni_add_sub.sv
// Combinational modular adder/subtractor.
//   a_i, b_i : operands in [0, Q-1]
//   sub_i    : 0 -> (a + b) mod Q, 1 -> (a - b) mod Q
//   res_o    : result in [0, Q-1]
module mod_uni_add_sub #(
  parameter int COEF_W = poly_arith_pkg::COEF_W,
  parameter int Q      = poly_arith_pkg::Q
) (
  input  logic [COEF_W-1:0] a_i,
  input  logic [COEF_W-1:0] b_i,
  input  logic              sub_i,
  output logic [COEF_W-1:0] res_o
);

  localparam int RAW_W = COEF_W + 2;
  localparam logic signed [RAW_W-1:0] Q_S = RAW_W'(Q);

  // A single conditional correction suffices: the raw value lies in (-Q, 2Q).
  function automatic logic [COEF_W-1:0] mod_reduce(input logic signed [RAW_W-1:0] x);
    logic signed [RAW_W-1:0] y;
    if (x[RAW_W-1]) begin
      y = x + Q_S;
    end else if (x >= Q_S) begin
      y = x - Q_S;
    end else begin
      y = x;
    end
    return y[COEF_W-1:0];
  endfunction

  logic signed [RAW_W-1:0] a_s;
  logic signed [RAW_W-1:0] b_s;
  logic signed [RAW_W-1:0] raw;

  assign a_s   = $signed({2'b00, a_i});
  assign b_s   = $signed({2'b00, b_i});
  assign raw   = sub_i ? (a_s - b_s) : (a_s + b_s);
  assign res_o = mod_reduce(raw);

endmodule

// File: rtl/poly_add_sub_ctrl.sv
// Sequencer for coefficient-wise polynomial add/sub mod Q.
// Streams N_COEFFS coefficient pairs from source memories A and B through
// mod_uni_add_sub and writes each result to the destination memory.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : command/status and memory ports (poly_add_sub_ctrl_if.master)
// Read issued in cycle k is written back in cycle k+2.
module poly_add_sub_ctrl #(
  parameter int N_COEFFS = poly_arith_pkg::N_COEFFS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  poly_add_sub_ctrl_if.master  bus
);
  import poly_arith_pkg::*;

  localparam int ADDR_W = $clog2(N_COEFFS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_COEFFS - 1);

  pas_state_t        state_q;
  logic              op_sub_q;
  logic              drain_q;
  logic              busy_q;
  logic              done_q;
  logic              rd_en_q;
  logic [ADDR_W-1:0] rd_cnt_q;

  logic              rd_vld_p1;
  logic [ADDR_W-1:0] rd_addr_p1;
  coeff_t            res_p1;

  logic              wr_en_p2;
  logic [ADDR_W-1:0] wr_addr_p2;
  coeff_t            wr_data_p2;

  // Control FSM; the read counter is the read address itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_sub_q <= 1'b0;
      drain_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_en_q  <= 1'b0;
      rd_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            state_q  <= RUN;
            op_sub_q <= bus.is_sub_i;
            rd_cnt_q <= '0;
            rd_en_q  <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        RUN: begin
          if (rd_cnt_q == LAST_ADDR) begin
            state_q <= DRAIN;
            rd_en_q <= 1'b0;
            drain_q <= 1'b0;
          end else begin
            rd_cnt_q <= rd_cnt_q + 1'b1;
          end
        end
        DRAIN: begin
          // Two cycles cover the two-stage read-to-write pipeline.
          if (drain_q) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            drain_q <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Stage 1: read outstanding, memory data arrives this cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_p1 <= 1'b0;
    end else begin
      rd_vld_p1 <= rd_en_q;
    end
  end

  always_ff @(posedge clk) begin
    rd_addr_p1 <= rd_cnt_q;
  end

  mod_uni_add_sub #(
    .COEF_W (COEF_W),
    .Q      (Q)
  ) u_mod_uni_add_sub (
    .a_i   (bus.rd_a_data_i),
    .b_i   (bus.rd_b_data_i),
    .sub_i (op_sub_q),
    .res_o (res_p1)
  );

  // Stage 2: registered write port (cleared on reset because it is a block output)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_p2   <= 1'b0;
      wr_addr_p2 <= '0;
      wr_data_p2 <= '0;
    end else begin
      wr_en_p2   <= rd_vld_p1;
      wr_addr_p2 <= rd_addr_p1;
      wr_data_p2 <= res_p1;
    end
  end

  assign bus.busy_o    = busy_q;
  assign bus.done_o    = done_q;
  assign bus.rd_en_o   = rd_en_q;
  assign bus.rd_addr_o = rd_cnt_q;
  assign bus.wr_en_o   = wr_en_p2;
  assign bus.wr_addr_o = wr_addr_p2;
  assign bus.wr_data_o = wr_data_p2;

endmodule

// File: tb/tb_poly_add_sub_ctrl.sv
// Self-checking bench for poly_add_sub_ctrl: source memories, a cycle-level
// reference model, a per-cycle compare process and directed scenarios.
module tb_poly_add_sub_ctrl;
  import poly_arith_pkg::*;

  localparam int N = 256;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  poly_add_sub_ctrl_if #(.N_COEFFS(N)) bus();

  poly_add_sub_ctrl #(.N_COEFFS(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int ref_op(input int a, input int b, input bit sub);
    if (sub) return (a - b + Q) % Q;
    return (a + b) % Q;
  endfunction

  // Source memories with one-cycle read latency
  int mem_a [N];
  int mem_b [N];
  coeff_t rda = '0;
  coeff_t rdb = '0;
  assign bus.rd_a_data_i = rda;
  assign bus.rd_b_data_i = rdb;

  always @(posedge clk) begin
    if (bus.rd_en_o) begin
      rda <= coeff_t'(mem_a[bus.rd_addr_o]);
      rdb <= coeff_t'(mem_b[bus.rd_addr_o]);
    end
  end

  // Reference model: t = cycles since the accepting edge, -1 when idle.
  int t   = -1;
  bit op_m = 1'b0;
  int cyc = 0;
  int e0  = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t <= -1;
    end else begin
      cyc <= cyc + 1;
      if (t < 0) begin
        if (bus.start_i) begin
          t    <= 0;
          op_m <= bus.is_sub_i;
          e0   <= cyc + 1;
        end
      end else if (t == N + 2) begin
        t <= -1;
      end else begin
        t <= t + 1;
      end
    end
  end

  // Compare process and event monitor
  int wr_count   = 0;
  int done_count = 0;
  int cap [N];
  int done_q [$];
  int rise_q [$];
  int rise_addr_q [$];
  bit prev_rd = 1'b0;

  always @(negedge clk) begin
    int k;
    bit e_rd, e_wr, e_busy, e_done;
    k      = t;
    e_rd   = (k >= 0) && (k < N);
    e_wr   = (k >= 2) && (k <= N + 1);
    e_busy = (k >= 0) && (k <= N + 1);
    e_done = (k == N + 2);
    check("rd_en", int'(bus.rd_en_o), int'(e_rd));
    check("wr_en", int'(bus.wr_en_o), int'(e_wr));
    check("busy", int'(bus.busy_o), int'(e_busy));
    check("done", int'(bus.done_o), int'(e_done));
    if (e_rd) check("rd_addr", int'(bus.rd_addr_o), k);
    if (e_wr) begin
      check("wr_addr", int'(bus.wr_addr_o), k - 2);
      check("wr_data", int'(bus.wr_data_o), ref_op(mem_a[k-2], mem_b[k-2], op_m));
    end
    if (bus.wr_en_o) begin
      cap[bus.wr_addr_o] = int'(bus.wr_data_o);
      wr_count++;
    end
    if (bus.done_o) begin
      done_count++;
      done_q.push_back(cyc);
    end
    if (bus.rd_en_o && !prev_rd) begin
      rise_q.push_back(cyc);
      rise_addr_q.push_back(int'(bus.rd_addr_o));
    end
    prev_rd = bus.rd_en_o;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic run_op(input bit sub);
    bus.start_i  = 1'b1;
    bus.is_sub_i = sub;
    step();
    bus.start_i = 1'b0;
    repeat (N + 5) step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int wb, db, rb, e0_first;
    bus.start_i  = 1'b1;
    bus.is_sub_i = 1'b0;
    for (int k = 0; k < N; k++) begin
      mem_a[k] = 0;
      mem_b[k] = 0;
    end

    // Reset held with start_i high
    repeat (3) step();
    check("rst_rd_en", int'(bus.rd_en_o), 0);
    check("rst_rd_addr", int'(bus.rd_addr_o), 0);
    check("rst_wr_en", int'(bus.wr_en_o), 0);
    check("rst_wr_addr", int'(bus.wr_addr_o), 0);
    check("rst_wr_data", int'(bus.wr_data_o), 0);
    check("rst_busy", int'(bus.busy_o), 0);
    check("rst_done", int'(bus.done_o), 0);
    bus.start_i = 1'b0;
    rst_n = 1'b1;
    repeat (10) step();
    check("idle_writes", wr_count, 0);
    check("idle_reads", rise_q.size(), 0);

    // Add: A[k] = k, B[k] = 3328
    for (int k = 0; k < N; k++) begin
      mem_a[k] = k;
      mem_b[k] = 3328;
    end
    wb = wr_count; db = done_count;
    run_op(1'b0);
    check("add_writes", wr_count - wb, 256);
    check("add_dones", done_count - db, 1);
    check("add_done_cycle", done_q[done_q.size()-1] - e0, 258);
    check("add_d0", cap[0], 3328);
    check("add_d1", cap[1], 0);
    check("add_d100", cap[100], 99);
    check("add_d255", cap[255], 254);

    // Sub: A[k] = 0, B[k] = k
    for (int k = 0; k < N; k++) begin
      mem_a[k] = 0;
      mem_b[k] = k;
    end
    wb = wr_count; db = done_count;
    run_op(1'b1);
    check("sub_writes", wr_count - wb, 256);
    check("sub_dones", done_count - db, 1);
    check("sub_d0", cap[0], 0);
    check("sub_d1", cap[1], 3328);
    check("sub_d255", cap[255], 3074);

    // Start pulse and is_sub_i toggling while busy: sub latched, one op only
    for (int k = 0; k < N; k++) begin
      mem_a[k] = 10 * k;
      mem_b[k] = 13 * k;
    end
    wb = wr_count; db = done_count;
    bus.start_i  = 1'b1;
    bus.is_sub_i = 1'b1;
    step();
    bus.start_i = 1'b0;
    for (int c = 1; c <= N + 5; c++) begin
      bus.is_sub_i = ~bus.is_sub_i;
      bus.start_i  = (c == 100);
      step();
    end
    bus.start_i  = 1'b0;
    bus.is_sub_i = 1'b0;
    check("busy_ign_writes", wr_count - wb, 256);
    check("busy_ign_dones", done_count - db, 1);
    check("busy_ign_d10", cap[10], 3299);
    check("busy_ign_d255", cap[255], 2564);

    // Reset in cycle 50 of an add
    for (int k = 0; k < N; k++) begin
      mem_a[k] = k;
      mem_b[k] = 3328;
    end
    db = done_count;
    bus.start_i = 1'b1;
    step();
    bus.start_i = 1'b0;
    repeat (50) step();
    rst_n = 1'b0;
    #1;
    check("midrst_rd_en", int'(bus.rd_en_o), 0);
    check("midrst_wr_en", int'(bus.wr_en_o), 0);
    check("midrst_busy", int'(bus.busy_o), 0);
    repeat (3) step();
    rst_n = 1'b1;
    repeat (5) step();
    check("midrst_no_done", done_count - db, 0);
    wb = wr_count; rb = rise_q.size();
    run_op(1'b0);
    check("restart_writes", wr_count - wb, 256);
    check("restart_rise", rise_q.size() - rb, 1);
    check("restart_addr0", rise_addr_q[rise_addr_q.size()-1], 0);
    check("restart_d0", cap[0], 3328);

    // Back-to-back with start_i held high
    db = done_count; rb = rise_q.size();
    bus.start_i = 1'b1;
    step();
    e0_first = e0;
    repeat (N + 5) step();
    bus.start_i = 1'b0;
    repeat (N + 6) step();
    check("b2b_dones", done_count - db, 2);
    check("b2b_rises", rise_q.size() - rb, 2);
    if (rise_q.size() - rb == 2)
      check("b2b_rise_cycle", rise_q[rb+1] - e0_first, 260);
    if (done_count - db == 2)
      check("b2b_done_gap", done_q[db+1] - done_q[db], 260);

    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
